// File: rtl/alu_ctrl_pkg.sv
// Shared FSM state, opcode map and flag bit positions for the ALU request arbiter.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam int OP_ADD  = 1;
  localparam int OP_ADDC = 2;
  localparam int OP_SUB  = 3;
  localparam int OP_SUBB = 4;
  localparam int OP_AND  = 5;
  localparam int OP_OR   = 6;
  localparam int OP_XOR  = 7;
  localparam int OP_NOT  = 8;
  localparam int OP_SHL  = 9;
  localparam int OP_SHR  = 10;
  localparam int OP_ROL  = 11;
  localparam int OP_MAX  = 11;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_CARRY = 2;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant with a last-grant pointer updated on response completion.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_update,
  input  logic       i_update_id,
  output logic [1:0] o_grant
);

  logic r_last;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (i_update) begin
      r_last <= i_update_id;
    end
  end

  // NOTE: default assignment first so no path through this block infers a latch.
  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external ALU, one transaction in flight at a time.
// Define ALU_CARRY_CHAIN_EN to keep a per-requester carry fed back into inputCarry.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int ALUOP = 4
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [1:0]         reqValid,
  output logic [1:0]         reqReady,
  input  logic [2*ALUOP-1:0] reqFunction,
  input  logic [2*BITS-1:0]  reqA,
  input  logic [2*BITS-1:0]  reqB,
  output logic               rspValid,
  input  logic               rspReady,
  output logic               rspId,
  output logic [BITS-1:0]    rspResult,
  output logic [2:0]         rspFlags,
  output logic               rspError,
  output logic [ALUOP-1:0]   aluFunction,
  output logic [BITS-1:0]    vectorA,
  output logic [BITS-1:0]    vectorB,
  output logic               inputCarry,
  input  logic [BITS-1:0]    aluResult,
  input  logic               overflow,
  input  logic               zero,
  input  logic               outputCarry
);

  state_t           r_state;
  logic             r_id;
  logic [ALUOP-1:0] r_op;
  logic [BITS-1:0]  r_a;
  logic [BITS-1:0]  r_b;

  logic [1:0] w_grant;
  logic       w_gid;
  logic       w_accept;
  logic       w_rsp_done;
  logic       w_op_ok;
  logic       w_issue;
  logic       w_cin;

  rr_arbiter2 u_arb (
    .clk         (clk),
    .rst_n       (resetN),
    .i_req       (reqValid),
    .i_update    (w_rsp_done),
    .i_update_id (rspId),
    .o_grant     (w_grant)
  );

  assign w_gid      = w_grant[1];
  assign w_accept   = (r_state == ST_IDLE) && (w_grant != 2'b00);
  assign w_rsp_done = (r_state == ST_RESP) && rspReady;
  assign w_op_ok    = (r_op != '0) && (r_op <= ALUOP'(OP_MAX));
  assign w_issue    = (r_state == ST_ISSUE) && w_op_ok;

  // Strobe is gated by reset only at the port; internal state is already held by reset.
  assign reqReady = ((r_state == ST_IDLE) && resetN) ? w_grant : 2'b00;

`ifdef ALU_CARRY_CHAIN_EN
  logic [1:0] r_carry;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_carry <= 2'b00;
    end else if (w_issue) begin
      r_carry[r_id] <= outputCarry;
    end
  end

  assign w_cin = r_carry[r_id];
`else
  assign w_cin = 1'b0;
`endif

  // Unsupported opcodes never reach the ALU: its ports stay at zero.
  assign aluFunction = w_issue ? r_op : '0;
  assign vectorA     = w_issue ? r_a  : '0;
  assign vectorB     = w_issue ? r_b  : '0;
  assign inputCarry  = w_issue & w_cin;

  // NOTE: operand latches are reset too so the ALU ports and responses are never X after reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state   <= ST_IDLE;
      r_id      <= 1'b0;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      rspValid  <= 1'b0;
      rspId     <= 1'b0;
      rspResult <= '0;
      rspFlags  <= 3'b000;
      rspError  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_id    <= w_gid;
            r_op    <= w_gid ? reqFunction[ALUOP +: ALUOP] : reqFunction[0 +: ALUOP];
            r_a     <= w_gid ? reqA[BITS +: BITS] : reqA[0 +: BITS];
            r_b     <= w_gid ? reqB[BITS +: BITS] : reqB[0 +: BITS];
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          rspValid             <= 1'b1;
          rspId                <= r_id;
          rspError             <= ~w_op_ok;
          rspResult            <= w_op_ok ? aluResult : '0;
          rspFlags[FLAG_CARRY] <= w_op_ok & outputCarry;
          rspFlags[FLAG_OVF]   <= w_op_ok & overflow;
          rspFlags[FLAG_ZERO]  <= w_op_ok & zero;
          r_state              <= ST_RESP;
        end
        ST_RESP: begin
          if (rspReady) begin
            rspValid <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a request monitor predicts grants and responses, a response monitor checks them.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        resetN;
  logic [1:0]  reqValid;
  logic [1:0]  reqReady;
  logic [7:0]  reqFunction;
  logic [15:0] reqA;
  logic [15:0] reqB;
  logic        rspValid;
  logic        rspReady;
  logic        rspId;
  logic [7:0]  rspResult;
  logic [2:0]  rspFlags;
  logic        rspError;
  logic [3:0]  aluFunction;
  logic [7:0]  vectorA;
  logic [7:0]  vectorB;
  logic        inputCarry;
  logic [7:0]  aluResult;
  logic        overflow;
  logic        zero;
  logic        outputCarry;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter #(.BITS(8), .ALUOP(4)) dut (
    .clk         (clk),
    .resetN      (resetN),
    .reqValid    (reqValid),
    .reqReady    (reqReady),
    .reqFunction (reqFunction),
    .reqA        (reqA),
    .reqB        (reqB),
    .rspValid    (rspValid),
    .rspReady    (rspReady),
    .rspId       (rspId),
    .rspResult   (rspResult),
    .rspFlags    (rspFlags),
    .rspError    (rspError),
    .aluFunction (aluFunction),
    .vectorA     (vectorA),
    .vectorB     (vectorB),
    .inputCarry  (inputCarry),
    .aluResult   (aluResult),
    .overflow    (overflow),
    .zero        (zero),
    .outputCarry (outputCarry)
  );

  typedef struct packed {
    logic [7:0] res;
    logic       c;
    logic       v;
    logic       z;
  } alu_out_t;

  // Behavioural external ALU; unsupported opcodes return a loud non-zero pattern.
  function automatic alu_out_t alu_eval(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic cin);
    alu_out_t   o;
    logic [8:0] s;
    o = '0;
    s = '0;
    case (op)
      4'd1:  begin s = {1'b0, a} + {1'b0, b};               o.res = s[7:0]; o.c = s[8];
                   o.v = (a[7] == b[7]) && (s[7] != a[7]); end
      4'd2:  begin s = {1'b0, a} + {1'b0, b} + {8'b0, cin}; o.res = s[7:0]; o.c = s[8];
                   o.v = (a[7] == b[7]) && (s[7] != a[7]); end
      4'd3:  begin s = {1'b0, a} - {1'b0, b};               o.res = s[7:0]; o.c = s[8];
                   o.v = (a[7] != b[7]) && (s[7] != a[7]); end
      4'd4:  begin s = {1'b0, a} - {1'b0, b} - {8'b0, cin}; o.res = s[7:0]; o.c = s[8];
                   o.v = (a[7] != b[7]) && (s[7] != a[7]); end
      4'd5:  o.res = a & b;
      4'd6:  o.res = a | b;
      4'd7:  o.res = a ^ b;
      4'd8:  o.res = ~a;
      4'd9:  begin o.res = {a[6:0], 1'b0}; o.c = a[7]; end
      4'd10: begin o.res = {1'b0, a[7:1]}; o.c = a[0]; end
      4'd11: begin o.res = {a[6:0], a[7]}; o.c = a[7]; end
      default: begin o.res = 8'hA5; o.c = 1'b1; o.v = 1'b1; o.z = 1'b1; return o; end
    endcase
    o.z = (o.res == 8'h00);
    return o;
  endfunction

  alu_out_t alu_o;
  always_comb alu_o = alu_eval(aluFunction, vectorA, vectorB, inputCarry);
  assign aluResult   = alu_o.res;
  assign outputCarry = alu_o.c;
  assign overflow    = alu_o.v;
  assign zero        = alu_o.z;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Round-robin rule: a lone request wins; with both, the one not granted last wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] v, input logic last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  typedef struct {
    logic       id;
    logic [7:0] res;
    logic [2:0] flags;
    logic       err;
    int         acc;
  } exp_t;

  exp_t sb[$];

  // Request-side model: one transaction in flight, response due two cycles after accept.
  logic        m_busy = 1'b0;
  logic        m_last = 1'b1;
  int          m_acc  = 0;
  logic        m_ok   = 1'b0;
  logic [3:0]  m_op   = '0;
  logic [7:0]  m_a    = '0;
  logic [7:0]  m_b    = '0;
  logic        m_cin  = 1'b0;
  logic [1:0]  m_carry = 2'b00;

  initial begin
    forever begin
      @(negedge clk);
      if (!resetN) begin
        m_busy  = 1'b0;
        m_last  = 1'b1;
        m_carry = 2'b00;
        check("rst_req_ready", 32'(reqReady), 32'd0);
        check("rst_alu_drive", 32'({aluFunction, vectorA, vectorB, inputCarry}), 32'd0);
      end else begin
        logic [1:0]  exp_g;
        logic [20:0] exp_drive;
        exp_drive = (m_busy && cyc == m_acc + 1 && m_ok) ? {m_op, m_a, m_b, m_cin} : 21'd0;
        check("alu_drive", 32'({aluFunction, vectorA, vectorB, inputCarry}), 32'(exp_drive));
        exp_g = m_busy ? 2'b00 : rr_pick(reqValid, m_last);
        check("req_ready", 32'(reqReady), 32'(exp_g));
        if (m_busy) begin
          if (cyc >= m_acc + 2 && rspReady) m_busy = 1'b0;
        end else if (exp_g != 2'b00) begin
          exp_t     e;
          alu_out_t o;
          logic     gid;
          gid  = exp_g[1];
          m_op = reqFunction[gid*4 +: 4];
          m_a  = reqA[gid*8 +: 8];
          m_b  = reqB[gid*8 +: 8];
          m_ok = (m_op >= 4'd1) && (m_op <= 4'd11);
`ifdef ALU_CARRY_CHAIN_EN
          m_cin = m_carry[gid];
`else
          m_cin = 1'b0;
`endif
          o       = alu_eval(m_op, m_a, m_b, m_cin);
          e.id    = gid;
          e.res   = m_ok ? o.res : 8'h00;
          e.flags = m_ok ? {o.c, o.v, o.z} : 3'b000;
          e.err   = ~m_ok;
          e.acc   = cyc;
          sb.push_back(e);
          if (m_ok) m_carry[gid] = o.c;
          m_last = gid;
          m_busy = 1'b1;
          m_acc  = cyc;
        end
      end
    end
  end

  // Response monitor: latency, hold-while-stalled, and payload against the scoreboard.
  logic        holding = 1'b0;
  logic [12:0] held    = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!resetN) begin
        sb.delete();
        holding = 1'b0;
        check("rst_rsp", 32'({rspValid, rspId, rspResult, rspFlags, rspError}), 32'd0);
      end else if (rspValid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(rspValid), 32'd0);
        end else begin
          if (!holding) begin
            check("rsp_latency", 32'(cyc), 32'(sb[0].acc + 2));
            held    = {rspId, rspResult, rspFlags, rspError};
            holding = 1'b1;
          end else begin
            check("rsp_stable", 32'({rspId, rspResult, rspFlags, rspError}), 32'(held));
          end
          if (rspReady) begin
            check("rsp_id",     32'(rspId),     32'(sb[0].id));
            check("rsp_result", 32'(rspResult), 32'(sb[0].res));
            check("rsp_flags",  32'(rspFlags),  32'(sb[0].flags));
            check("rsp_error",  32'(rspError),  32'(sb[0].err));
            void'(sb.pop_front());
            holding = 1'b0;
          end
        end
      end else if (sb.size() > 0 && cyc >= sb[0].acc + 2) begin
        check("rsp_late", 32'(rspValid), 32'd1);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] v, input logic [3:0] f0, input logic [7:0] a0,
                         input logic [7:0] b0, input logic [3:0] f1, input logic [7:0] a1,
                         input logic [7:0] b1, input logic rdy);
    reqValid    = v;
    reqFunction = {f1, f0};
    reqA        = {a1, a0};
    reqB        = {b1, b0};
    rspReady    = rdy;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    resetN = 1'b0;
    set_req(2'b11, 4'd1, 8'h11, 8'h22, 4'd3, 8'h33, 8'h44, 1'b1);
    #1;
    check("rst_ready_now", 32'(reqReady), 32'd0);
    step(3);
    set_req(2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 1'b1);
    resetN = 1'b1;
    step(1);

    // Lone requester 0: signed-overflowing add with carry and zero.
    set_req(2'b01, 4'd1, 8'h80, 8'h80, 4'd0, 8'h00, 8'h00, 1'b1);
    #1;
    check("first_grant", 32'(reqReady), 32'd1);
    step(1);
    set_req(2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 1'b1);
    step(4);

    // Both requesting continuously with an always-ready consumer.
    set_req(2'b11, 4'd3, 8'h05, 8'h07, 4'd7, 8'hF0, 8'h3C, 1'b1);
    step(13);

    // Consumer stalls in RESP while both keep requesting.
    set_req(2'b01, 4'd5, 8'hCA, 8'h0F, 4'd6, 8'h12, 8'h34, 1'b0);
    step(1);
    set_req(2'b11, 4'd5, 8'hCA, 8'h0F, 4'd6, 8'h12, 8'h34, 1'b0);
    step(7);
    rspReady = 1'b1;
    step(1);
    set_req(2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 1'b1);
    step(4);

    // Unsupported opcode on requester 1.
    set_req(2'b10, 4'd0, 8'h00, 8'h00, 4'd13, 8'h5A, 8'hA5, 1'b1);
    step(1);
    set_req(2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 1'b1);
    step(4);

    // Requester 1 carry-producing add followed by add-with-carry.
    set_req(2'b10, 4'd0, 8'h00, 8'h00, 4'd1, 8'hFF, 8'h01, 1'b1);
    step(1);
    set_req(2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 1'b1);
    step(3);
    set_req(2'b10, 4'd0, 8'h00, 8'h00, 4'd2, 8'h10, 8'h20, 1'b1);
    step(1);
    set_req(2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 1'b1);
    step(4);

    for (int i = 0; i < 400; i++) begin
      set_req(2'($urandom), 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
              4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
              1'($urandom_range(0, 3) != 0));
      step(1);
    end
    set_req(2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 1'b1);
    step(6);

    // Reset pulse while a response is pending.
    set_req(2'b01, 4'd3, 8'h40, 8'h10, 4'd0, 8'h00, 8'h00, 1'b0);
    step(1);
    set_req(2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 1'b0);
    step(3);
    check("pre_reset_rsp_valid", 32'(rspValid), 32'd1);
    resetN = 1'b0;
    #1;
    check("reset_drops_rsp_valid", 32'(rspValid), 32'd0);
    step(2);
    set_req(2'b11, 4'd1, 8'h01, 8'h02, 4'd1, 8'h03, 8'h04, 1'b1);
    resetN = 1'b1;
    #1;
    check("post_reset_grant", 32'(reqReady), 32'd1);
    step(1);
    set_req(2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 1'b1);
    step(6);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter BITS, default 8, operand and result width.
REQ-002 Parameter ALUOP, default 4, opcode width.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 resetN  input  1  asynchronous, active-low reset.
REQ-005 reqValid  input  2  per-requester request valid, bit i = requester i.
REQ-006 reqReady  output  2  per-requester accept strobe, at most one bit high per cycle.
REQ-007 reqFunction  input  2*ALUOP  opcodes, requester i in slice [i*ALUOP +: ALUOP].
REQ-008 reqA  input  2*BITS  operand A, requester i in slice [i*BITS +: BITS].
REQ-009 reqB  input  2*BITS  operand B, same slicing as reqA.
REQ-010 rspValid  output  1  response valid.
REQ-011 rspReady  input  1  response consumer ready.
REQ-012 rspId  output  1  index of the requester owning the response.
REQ-013 rspResult  output  BITS  registered ALU result.
REQ-014 rspFlags  output  3  registered {carry, overflow, zero}.
REQ-015 rspError  output  1  unsupported opcode.
REQ-016 aluFunction, vectorA, vectorB, inputCarry  output  ALUOP/BITS/BITS/1  drive to the external ALU.
REQ-017 aluResult, overflow, zero, outputCarry  input  BITS/1/1/1  returned from the external ALU.

Function
REQ-018 FSM states IDLE, ISSUE, RESP; one transaction outstanding at a time.
REQ-019 IDLE: if any reqValid, grant g is chosen by round-robin, and reqReady[g] is asserted combinationally that cycle; operands and opcode are latched; next state ISSUE.
REQ-020 Round-robin: a single request always wins; with both valid, the requester not granted last wins.
REQ-021 reqReady is 0 in ISSUE and RESP.
REQ-022 ISSUE: ALU drive ports carry the latched values for exactly one cycle; at its end aluResult and flags are registered into the rsp* outputs; next state RESP.
REQ-023 Outside ISSUE, aluFunction, vectorA, vectorB and inputCarry are driven 0.
REQ-024 Latency: accept in cycle N gives rspValid high in cycle N+2.
REQ-025 RESP: rspValid is held at 1 and rsp* outputs are held stable until rspReady=1; on that edge the FSM goes to IDLE and the last-grant pointer is set to rspId.
REQ-026 A new accept cannot occur in the cycle of the response handshake; the earliest next reqReady is the following cycle.
REQ-027 Opcodes 0 and 12..15 skip the ALU; ISSUE still takes one cycle, and the response has rspError=1, rspResult=0, rspFlags=0.
REQ-028 rspFlags is registered carry=outputCarry, overflow=overflow, zero=zero, exactly as the ALU returned them.

Reset
REQ-029 While resetN=0: state IDLE, reqReady=0, rspValid=0, rspId=0, rspResult=0, rspFlags=0, rspError=0, ALU drive ports 0, last-grant=1 so requester 0 wins first.
REQ-030 Reset asserted mid-ISSUE or mid-RESP discards the transaction immediately; no response is produced after reset is released.

Configuration
REQ-031 Macro ALU_CARRY_CHAIN_EN defined: a per-requester carry register, reset 0, is loaded from outputCarry when that requester's valid-opcode ISSUE completes, and drives inputCarry during that requester's next ISSUE.
REQ-032 Macro undefined: no carry registers are present and inputCarry is constant 0.

Structure
REQ-033 Package alu_ctrl_pkg holds the FSM state enum, opcode constants OP_ADD=1..OP_ROL=11, OP_MAX=11, and the flag bit indices.
REQ-034 Sub-module rr_arbiter2 holds the round-robin grant logic and the last-grant pointer update.

Verification
REQ-035 Only reqValid=01, opcode 1, A=8'h80, B=8'h80 -> reqReady=01 in the same cycle; two cycles later rspValid=1, rspId=0, rspResult=8'h00, rspFlags=3'b111.
REQ-036 Both valid continuously, rspReady=1 -> grants alternate 0,1,0,1, with one accept every 3 cycles.
REQ-037 rspReady=0 for 5 cycles in RESP -> rsp* outputs stable, reqReady=00 throughout.
REQ-038 Opcode 4'd13 -> rspError=1, rspResult=0, rspFlags=0; ALU drive ports stay 0.
REQ-039 resetN pulsed low during RESP -> rspValid=0 immediately; next grant goes to requester 0.
REQ-040 With ALU_CARRY_CHAIN_EN: requester 1 add FF+01 produces carry=1, then requester 1 issues opcode 2 -> inputCarry=1 during its ISSUE cycle.
